soc_system_dps_byte_arbiter: RTL and testbench
==============================================

SOC_SYSTEM_DPS_BYTE_ARBITER -- requirements
Module: soc_system_dps_byte_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the byte-port width written to the PIO slave.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, meaning the reset: asynchronous and active-high.
REQ-005 The block SHALL have port req, input, NUM_REQ, meaning per-requester write request, held high until its done pulse.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*DATA_W, meaning per-requester byte, with requester i at bits [i*DATA_W +: DATA_W], held stable while req[i] is high.
REQ-007 The block SHALL have port grant, output, NUM_REQ, meaning one-hot owner of the slave; all zero when idle.
REQ-008 The block SHALL have port done, output, NUM_REQ, meaning one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port err, output, 1, meaning readback mismatch, valid only in the cycle where done is nonzero.
REQ-010 The block SHALL have port avm_chipselect, output, 1, meaning Avalon-MM select to the PIO slave.
REQ-011 The block SHALL have port avm_write_n, output, 1, meaning Avalon-MM active-low write.
REQ-012 The block SHALL have port avm_address, output, 2, meaning Avalon-MM word address, always 0.
REQ-013 The block SHALL have port avm_writedata, output, 32, meaning the granted byte zero-extended to 32 bits.
REQ-014 The block SHALL have port avm_readdata, input, 32, meaning the zero-wait combinational read data from the slave.
REQ-015 The block SHALL have port last_byte, output, DATA_W, meaning the shadow of the last byte successfully written.
REQ-016 The block SHALL have port wr_count, output, 16, meaning the count of completed transactions, wrapping at 0xFFFF to 0.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE, READ and DONE, and SHALL advance one state per cycle outside IDLE.
REQ-018 In IDLE with any req bit high, the FSM SHALL select a winner round-robin, starting after the last winner, with lowest index first after reset; it SHALL register the winner into grant and go to WRITE.
REQ-019 In IDLE with req all zero, the FSM SHALL stay in IDLE with grant=0.
REQ-020 In WRITE, the block SHALL drive avm_chipselect=1, avm_write_n=0, avm_address=0 and avm_writedata={24'b0, req_data[winner]} for exactly 1 cycle.
REQ-021 In READ, the block SHALL drive avm_chipselect=1, avm_write_n=1, avm_address=0, and SHALL sample avm_readdata[DATA_W-1:0] in that cycle.
REQ-022 In DONE, the block SHALL pulse done[winner]=1 and drive err=(sampled != written byte).
REQ-023 In DONE with err=0, last_byte SHALL update to the written byte; last_byte SHALL be unchanged when err=1.
REQ-024 In DONE, wr_count SHALL increment by 1, regardless of err.
REQ-025 After DONE, the FSM SHALL clear grant and return to IDLE; the next arbitration SHALL occur in that IDLE cycle.
REQ-026 Fixed latency: req seen in IDLE cycle k -> WRITE in cycle k+1 -> READ in cycle k+2 -> done in cycle k+3; the minimum request-to-request spacing is 4 cycles.
REQ-027 Outside WRITE and READ, the block SHALL drive avm_chipselect=0 and avm_write_n=1.
REQ-028 Requests arriving or dropping while a transaction is in flight SHALL NOT alter the current transaction; a dropped req of the winner is a protocol violation and the transaction SHALL still complete.
REQ-029 The round-robin pointer SHALL update only on a grant.

Reset
REQ-030 While reset is asserted, the block SHALL force FSM=IDLE, grant=0, done=0, err=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, last_byte=0, wr_count=0 and round-robin pointer=requester NUM_REQ-1, so that index 0 wins first.
REQ-031 Reset asserted mid-transaction SHALL abort it with no done pulse; the bus outputs SHALL go to idle values immediately (asynchronously).

Structure
REQ-032 The FSM state enumeration and the constants PIO_DATA_ADDR=0 and AVM_DATA_W=32 SHALL live in a shared package soc_system_dps_pkg.
REQ-033 The round-robin selector SHALL be one combinational sub-module soc_system_rr_pick (req, pointer in -> one-hot winner).

Verification
REQ-034 Single request: req=001, data0=0x5A -> write 0x5A at k+1, read at k+2, done=001 with err=0 at k+3, last_byte=0x5A, wr_count=1.
REQ-035 Fairness: req=111 held continuously -> grant order 0,1,2,0 with done pulses every 4 cycles.
REQ-036 Readback fault: slave model returns 0x00 for a write of 0xA5 -> err=1 with done, last_byte unchanged, wr_count incremented.
REQ-037 Mid-transaction reset: assert reset in READ -> no done pulse, chipselect=0 immediately, next req=010 granted to requester 0 first if req=011.
REQ-038 Wrap: preload 0xFFFF completions (or force) then one transaction -> wr_count=0.

Source files
------------

// File: rtl/soc_system_dps_pkg.sv
// Shared definitions for the DPS byte arbiter: FSM states and Avalon PIO constants.
package soc_system_dps_pkg;
  localparam int PIO_DATA_ADDR = 0;
  localparam int AVM_DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } dps_state_e;
endpackage

// File: rtl/soc_system_rr_pick.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module soc_system_rr_pick #(
  parameter int NUM_REQ = 3
)(
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         winner
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest one sticks.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = PW'((int'(ptr) + off) % NUM_REQ);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/soc_system_dps_byte_arbiter.sv
// Round-robin arbiter funnelling per-requester byte writes to one Avalon PIO slave,
// with write / readback / compare per transaction.
module soc_system_dps_byte_arbiter
  import soc_system_dps_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 8
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      avm_chipselect,
  output logic                      avm_write_n,
  output logic [1:0]                avm_address,
  output logic [AVM_DATA_W-1:0]     avm_writedata,
  input  logic [AVM_DATA_W-1:0]     avm_readdata,
  output logic [DATA_W-1:0]         last_byte,
  output logic [15:0]               wr_count
);
  localparam int PW = $clog2(NUM_REQ);

  dps_state_e        state;
  logic [PW-1:0]     ptr;
  logic [NUM_REQ-1:0] pick;
  logic [PW-1:0]     pick_idx;
  logic [DATA_W-1:0] pick_byte;
  logic [DATA_W-1:0] wbyte;
  logic              mismatch;

  soc_system_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = PW'(i);
  end

  assign pick_byte   = req_data[pick_idx*DATA_W +: DATA_W];
  // The write-data register doubles as the reference for the readback compare.
  assign wbyte       = avm_writedata[DATA_W-1:0];
  assign mismatch    = avm_readdata[DATA_W-1:0] != wbyte;
  assign avm_address = 2'(PIO_DATA_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= PW'(NUM_REQ - 1);
      grant          <= '0;
      done           <= '0;
      err            <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= '0;
      last_byte      <= '0;
      wr_count       <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state          <= WRITE;
            grant          <= pick;
            ptr            <= pick_idx;
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_writedata  <= AVM_DATA_W'(pick_byte);
          end
        end
        WRITE: begin
          state       <= READ;
          avm_write_n <= 1'b1;
        end
        READ: begin
          state          <= DONE;
          avm_chipselect <= 1'b0;
          done           <= grant;
          err            <= mismatch;
          if (!mismatch) last_byte <= wbyte;
          wr_count       <= wr_count + 16'd1;
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_soc_system_dps_byte_arbiter.sv
// Self-checking bench: directed scenarios plus randomized transactions against a
// transaction-level round-robin / readback model.
module tb_soc_system_dps_byte_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, grant, done;
  logic [N*DW-1:0] req_data;
  logic            err, cs, wn;
  logic [1:0]      addr;
  logic [31:0]     wdata, rdata;
  logic [DW-1:0]   last_byte;
  logic [15:0]     wr_count;

  logic [DW-1:0]   pio;
  logic            rd_zero;

  int              errors = 0;
  int              checks = 0;
  int              last_w;
  logic [15:0]     exp_cnt;
  logic [DW-1:0]   exp_last;

  always #5 clk = ~clk;

  soc_system_dps_byte_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_data       (req_data),
    .grant          (grant),
    .done           (done),
    .err            (err),
    .avm_chipselect (cs),
    .avm_write_n    (wn),
    .avm_address    (addr),
    .avm_writedata  (wdata),
    .avm_readdata   (rdata),
    .last_byte      (last_byte),
    .wr_count       (wr_count)
  );

  // PIO slave: one data register, zero-wait read; rd_zero models a broken readback.
  always @(posedge clk) if (cs && !wn) pio <= wdata[DW-1:0];
  assign rdata = rd_zero ? 32'h0 : {24'h0, pio};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++)
      if (r[(last + off) % N]) return (last + off) % N;
    return -1;
  endfunction

  function automatic void model_reset();
    last_w   = N - 1;
    exp_cnt  = 16'h0;
    exp_last = '0;
  endfunction

  // Entered at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic txn(input logic [N-1:0] r, input logic zero_rd);
    int            w;
    logic [DW-1:0] b;
    logic          e;
    req     = r;
    rd_zero = zero_rd;
    w       = rr_next(r, last_w);
    last_w  = w;
    b       = req_data[w*DW +: DW];
    e       = zero_rd && (b != '0);
    @(negedge clk);
    chk("wr_grant", 32'(grant), 32'(1) << w);
    chk("wr_cs",    32'(cs), 32'd1);
    chk("wr_wn",    32'(wn), 32'd0);
    chk("wr_addr",  32'(addr), 32'd0);
    chk("wr_data",  wdata, {24'h0, b});
    @(negedge clk);
    chk("rd_cs",    32'(cs), 32'd1);
    chk("rd_wn",    32'(wn), 32'd1);
    chk("rd_done",  32'(done), 32'd0);
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    if (!e) exp_last = b;
    chk("dn_done",  32'(done), 32'(1) << w);
    chk("dn_err",   32'(e ? err : err), 32'(e));
    chk("dn_cs",    32'(cs), 32'd0);
    chk("dn_last",  32'(last_byte), 32'(exp_last));
    chk("dn_cnt",   32'(wr_count), 32'(exp_cnt));
    @(negedge clk);
    chk("id_grant", 32'(grant), 32'd0);
    chk("id_done",  32'(done), 32'd0);
  endtask

  task automatic idle_gap();
    req = '0;
    @(negedge clk);
    chk("gap_grant", 32'(grant), 32'd0);
    chk("gap_cs",    32'(cs), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    rd_zero  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_cs",    32'(cs), 32'd0);
    chk("rst_wn",    32'(wn), 32'd1);
    chk("rst_addr",  32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_last",  32'(last_byte), 32'd0);
    chk("rst_cnt",   32'(wr_count), 32'd0);
    reset = 1'b0;

    // Single request from requester 0.
    req_data = {8'h11, 8'h22, 8'h5A};
    txn(3'b001, 1'b0);
    idle_gap();

    // Fairness with all three held: back-to-back transactions every 4 cycles.
    req_data = {8'hC3, 8'hB2, 8'hA1};
    repeat (4) txn(3'b111, 1'b0);
    idle_gap();

    // Readback fault: slave returns 0 for a write of 0xA5.
    req_data = {8'h00, 8'hA5, 8'h00};
    txn(3'b010, 1'b1);
    idle_gap();

    // Randomized traffic.
    for (int it = 0; it < 16; it++) begin
      req_data = N*DW'($urandom);
      txn(N'($urandom_range(1, (1 << N) - 1)), ($urandom_range(0, 3) == 0));
      idle_gap();
    end

    // Reset during READ: bus idles at once, no done pulse, pointer restarts at 0.
    rd_zero  = 1'b0;
    req_data = {8'h77, 8'h66, 8'h55};
    req      = 3'b011;
    @(negedge clk);
    @(negedge clk);
    chk("mr_in_read", 32'(cs & wn), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_cs",    32'(cs), 32'd0);
    chk("mr_wn",    32'(wn), 32'd1);
    chk("mr_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("mr_done",  32'(done), 32'd0);
    chk("mr_cnt",   32'(wr_count), 32'd0);
    model_reset();
    reset = 1'b0;
    txn(3'b011, 1'b0);
    idle_gap();

    // Counter wrap from 0xFFFF.
    force dut.wr_count = 16'hFFFF;
    @(negedge clk);
    release dut.wr_count;
    @(negedge clk);
    chk("wrap_pre", 32'(wr_count), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    req_data = {8'h3C, 8'h00, 8'h00};
    txn(3'b100, 1'b0);
    chk("wrap_zero", 32'(wr_count), 32'd0);
    idle_gap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
